// File: rtl/exec_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. It owns every architectural
// write strobe and the ALU source-A select.
package src_a_mux_pkg;
    typedef enum logic [1:0] {
        SEL_SRC_A_RS1 = 2'd0,
        SEL_SRC_A_PC  = 2'd1,
        SEL_SRC_A_IMM = 2'd2
    } sel_src_a_t;
endpackage

module exec_seq_ctrl
    import src_a_mux_pkg::*;
#(
    parameter logic RESET_PC_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         halt,
    input  logic [6:0]   opcode,
    input  logic         branch_taken,
    output logic         imem_req,
    input  logic         imem_ack,
    output logic         dmem_req,
    output logic         dmem_we,
    input  logic         dmem_ack,
    output logic         ir_we,
    output logic         reg_we,
    output logic         pc_we,
    output logic         pc_sel_target,
    output logic         pc_rst_req,
    output sel_src_a_t   sel_src_a,
    output logic         illegal,
    output logic         busy,
    output logic [31:0]  instret
);

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] instret_reg;
    logic        first_idle_reg;
    logic        retire;

    logic        op_legal, op_mem, op_store, op_branch, op_jump;
    sel_src_a_t  op_sel;

    assign op_legal  = (opcode == OP_ALU)  || (opcode == OP_ALUI)   || (opcode == OP_LOAD) ||
                       (opcode == OP_STORE)|| (opcode == OP_BRANCH) || (opcode == OP_JAL)  ||
                       (opcode == OP_JALR) || (opcode == OP_LUI)    || (opcode == OP_AUIPC);
    assign op_store  = (opcode == OP_STORE);
    assign op_mem    = (opcode == OP_LOAD) || op_store;
    assign op_branch = (opcode == OP_BRANCH);
    assign op_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

    always_comb begin
        op_sel = SEL_SRC_A_RS1;
        if ((opcode == OP_AUIPC) || (opcode == OP_JAL))
            op_sel = SEL_SRC_A_PC;
        else if (opcode == OP_LUI)
            op_sel = SEL_SRC_A_IMM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            instret_reg    <= 32'd0;
            first_idle_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            first_idle_reg <= 1'b0;
            if (retire)
                instret_reg <= instret_reg + 32'd1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        imem_req      = 1'b0;
        ir_we         = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_we        = 1'b0;
        pc_we         = 1'b0;
        pc_sel_target = 1'b0;
        illegal       = 1'b0;
        retire        = 1'b0;
        sel_src_a     = SEL_SRC_A_RS1;
        case (state_reg)
            S_IDLE: begin
                if (!halt)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = op_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                sel_src_a = op_sel;
                if (op_mem) begin
                    state_next = S_MEM;
                end else if (op_branch) begin
                    pc_we         = 1'b1;
                    pc_sel_target = branch_taken;
                    retire        = 1'b1;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                // Select stays at its EXEC value so the address remains stable.
                sel_src_a = op_sel;
                dmem_req  = 1'b1;
                dmem_we   = op_store;
                if (dmem_ack) begin
                    if (op_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                sel_src_a     = op_sel;
                reg_we        = 1'b1;
                pc_we         = 1'b1;
                pc_sel_target = op_jump;
                retire        = 1'b1;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (retire)
            state_next = halt ? S_IDLE : S_FETCH;
    end

    // Gated by rst so the request is quiet while reset is still held.
    assign pc_rst_req = RESET_PC_EN && first_idle_reg && !rst && (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign instret    = instret_reg;

endmodule

// File: doc/exec_seq_ctrl.md
# exec_seq_ctrl

Multi-cycle instruction sequencer for the core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and handshakes with instruction and data memory. It drives the ALU source-A select (`sel_src_a_t` from `src_a_mux_pkg`) together with the register-file, IR and PC write strobes. It sits between decode and the datapath muxes and owns the only architectural-state write enables.

## Interface
- `RESET_PC_EN`, default 1: when 1, `pc_rst_req` pulses once on leaving IDLE after reset.
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `halt`  in  1  sampled in IDLE and on every retirement; 1 parks the sequencer in IDLE
- `opcode`  in  7  `ir[6:0]` from decode, valid from DECODE onward
- `branch_taken`  in  1  ALU compare result, valid in EXEC
- `imem_req`  out  1  instruction fetch request
- `imem_ack`  in  1  instruction word valid this cycle
- `dmem_req`  out  1  data access request
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req`
- `dmem_ack`  in  1  data access complete this cycle
- `ir_we`  out  1  latch instruction register
- `reg_we`  out  1  register-file write strobe
- `pc_we`  out  1  PC update strobe
- `pc_sel_target`  out  1  1 = load ALU result into PC, 0 = pc+4
- `pc_rst_req`  out  1  load reset vector into PC
- `sel_src_a`  out  `sel_src_a_t`  ALU source-A select
- `illegal`  out  1  one-cycle pulse on unsupported opcode
- `busy`  out  1  state != IDLE
- `instret`  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. 3-bit state register, reset to IDLE.
- All outputs are Moore decodes of the state register and `opcode`. The exceptions are `ir_we` and the MEM exit, which also qualify on `imem_ack`/`dmem_ack`.
- IDLE: all strobes 0.
  - `halt`=0 → FETCH.
  - `pc_rst_req`=1 in the first IDLE cycle after reset release, when `RESET_PC_EN`=1.
- FETCH: `imem_req`=1 held until `imem_ack`.
  - On the `imem_ack` cycle, `ir_we`=1 and the next state is DECODE.
- DECODE: one cycle, no strobes.
  - Recognized opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Recognized → EXEC. Anything else → TRAP.
- EXEC: `sel_src_a` selects by opcode:
  - 0010111 (AUIPC) or 1101111 (JAL) → `SEL_SRC_A_PC`
  - 0110111 (LUI) → `SEL_SRC_A_IMM`
  - all others → `SEL_SRC_A_RS1`
- EXEC transitions:
  - Load/store → MEM.
  - Branch (1100011) → retire: `pc_we`=1, `pc_sel_target`=`branch_taken`.
  - All other opcodes → WB.
- MEM: `dmem_req`=1 held until `dmem_ack`; `dmem_we`=1 for 0100011.
  - On ack, a load goes to WB.
  - On ack, a store retires: `pc_we`=1, `pc_sel_target`=0.
- WB: `reg_we`=1 and `pc_we`=1. `pc_sel_target`=1 for JAL/JALR, else 0. Retire.
- `sel_src_a` is held at its EXEC value through MEM and WB, so ALU-derived addresses and results stay stable. It is `SEL_SRC_A_RS1` in IDLE, FETCH, DECODE and TRAP.
- Retire: `instret` += 1 (mod 2^32, 0xFFFFFFFF wraps to 0). Next state is FETCH if `halt`=0, else IDLE.
- TRAP: one cycle. `illegal`=1, no `pc_we`, no `instret` increment, next state IDLE.
- Reset mid-operation: state goes to IDLE and `instret` clears immediately (asynchronously). An in-flight request is dropped; a late ack arriving in IDLE is ignored.

## Timing
- Reset values: state=IDLE, `instret`=0, every 1-bit output 0, `sel_src_a`=`SEL_SRC_A_RS1`.
- First `imem_req` appears 1 cycle after `rst` deasserts (the IDLE cycle).
- Latencies with zero-wait memories (ack in the first request cycle):
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles (FETCH, DECODE, EXEC, WB)
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles
- Each memory wait cycle adds exactly 1 cycle.
- `pc_we` pulses exactly once per retired instruction, in its final cycle; `instret` updates on the same edge.
- `halt` is ignored outside IDLE and retirement cycles; it never aborts an instruction.
- `imem_req` and `dmem_req` are never high together.

## Test plan
- Reset release, `halt`=0, ADD (0110011), imem ack immediate → `imem_req` high 1 cycle after reset deasserts. `reg_we`+`pc_we` in cycle 4 of the instruction with `sel_src_a`=RS1, `pc_sel_target`=0. `instret`=1.
- Load with `dmem_ack` delayed 3 cycles → `dmem_req` high for 3 cycles then WB. Total 7 cycles, `dmem_we`=0 throughout.
- AUIPC then LUI back-to-back → `sel_src_a`=PC during the first EXEC/WB, then IMM during the second. `instret`=2.
- Branch with `branch_taken`=1, then one with `branch_taken`=0 → 3-cycle instructions, `pc_sel_target`=1 then 0. `reg_we` never asserted.
- Opcode 0000000 → `illegal` pulses one cycle, state returns to IDLE, `instret` unchanged. With `halt`=0 the next fetch starts 1 cycle later.
- `instret` preloaded by running to 0xFFFFFFFF, retire one → 0. Then assert `rst` during MEM with `dmem_req`=1 → all outputs 0 immediately and `instret`=0; a `dmem_ack` arriving in IDLE is ignored.
